data_bus: RTL and testbench
===========================

# data_bus

Word-addressed data/instruction bus slave that sits directly downstream of the single-cycle `cpu`. It consumes the `cpu_addr_bus`, `cpu_rd`, `cpu_wr` and `cpu_data_out_bus` outputs and returns `cpu_data_in_bus`. It decodes each access to one of three targets: on-chip RAM, a memory-mapped console transmit FIFO, or a console status register. The FIFO drains through a valid/ready port to an external character sink, which replaces simulation-only `$write` output with real hardware.

## Interface
Parameters:
- `MEM_WORDS`, 1024: RAM depth in 32-bit words; byte range is `0 .. MEM_WORDS*4-1`.
- `CON_TX_ADDR`, 32'hFFFF_0000: write-only console data register.
- `CON_STAT_ADDR`, 32'hFFFF_0004: read-only console status register.
- `FIFO_DEPTH`, 8: console FIFO entries; must be a power of 2, ≥ 2.

Ports:
- `bus_clk` in 1: single clock.
- `bus_rst` in 1: reset, synchronous, active-high.
- `bus_addr` in 32: byte address, driven from `cpu_addr_bus`.
- `bus_wdata` in 32: write data, driven from `cpu_data_out_bus`.
- `bus_rd` in 1: read strobe.
- `bus_wr` in 1: write strobe.
- `bus_rdata` out 32: read data, drives `cpu_data_in_bus`.
- `bus_err` out 1: access fault for the current cycle.
- `con_data` out 8: head character of the FIFO.
- `con_valid` out 1: FIFO is non-empty.
- `con_ready` in 1: sink accepts `con_data` this cycle.

## Operation
- **Decode:** each address falls into exactly one of RAM, TX, STAT or unmapped.
  - Misaligned (`bus_addr[1:0] != 0`) or unmapped with `bus_rd|bus_wr` → `bus_err`=1.
  - On a fault, no state changes and `bus_rdata`=0.
- **RAM read:** combinational. `bus_rdata = ram[bus_addr[31:2]]` while `bus_rd`. This keeps the CPU single-cycle, because instruction fetch and load complete in the same cycle.
- **RAM write:** on `posedge bus_clk` when `bus_wr` and the address is in range, store all 32 bits.
- **TX write:** pushes `bus_wdata[7:0]`; the upper bits are ignored.
  - When the FIFO is full, the byte is dropped and sticky `ovf` is set.
  - A TX read is a fault.
- **STAT read:** returns `{29'b0, ovf, full, empty}`.
  - Reading STAT clears `ovf` at the next edge.
  - If a dropped push and a STAT read occur in the same cycle, `ovf` ends at 1 (set wins).
  - A STAT write is a fault.
- **`bus_rd` and `bus_wr` both high:** this is a fault. No write occurs and `bus_rdata`=0.
- **Neither strobe high:** `bus_rdata`=0 and `bus_err`=0.
- **Drain:** a pop occurs when `con_valid & con_ready`. `con_data` always shows the head entry and is 0 when empty.
- **FIFO counters:** read and write pointers wrap modulo `FIFO_DEPTH`. An occupancy count of `log2(FIFO_DEPTH)+1` bits distinguishes full from empty.
- **Push and pop in the same cycle:**
  - When neither full nor empty, both occur and the count is unchanged.
  - When full, the pop occurs first, so the push is accepted and there is no overflow.
  - When empty, only the push occurs, because `con_valid`=0.

## Timing
- **Reset values:**
  - `con_valid`=0, `con_data`=0, FIFO empty, `ovf`=0.
  - `bus_rdata`=0 and `bus_err`=0 while strobes are low.
  - RAM contents are not cleared; RAM is loaded via `$readmemh` in the testbench.
- **`bus_rst` mid-operation:** at the edge it empties the FIFO and clears `ovf`. Any write presented in that cycle is ignored, whether to RAM or TX.
- **Read latency:** 0 cycles, combinational from `bus_addr` and `bus_rd`.
- **Write latency:** 1 edge.
  - A write then a read of the same RAM word sees the new data in the following cycle.
  - A TX push asserts `con_valid` in the cycle after the edge.
- **`con_valid`/`con_data`:** registered, taken from pointer state only; there is no combinational path from `con_ready`.
- **Sink contract:** `con_data` is stable while `con_valid` is high and `con_ready` is low.
- **Throughput:** at most 1 push and 1 pop per cycle.

## Structure
- **Package `bus_pkg`:**
  - Address-map constants: `CON_TX_ADDR`, `CON_STAT_ADDR`.
  - STAT bit indices: `STAT_EMPTY`=0, `STAT_FULL`=1, `STAT_OVF`=2.
  - Region enum: `REG_RAM`, `REG_TX`, `REG_STAT`, `REG_NONE`.
- **Sub-module `con_fifo`:** parameterized synchronous FIFO (width 8, depth `FIFO_DEPTH`) with push/pop/full/empty/count.
- **Top level** holds the decoder, RAM array, `ovf` flag and read mux.

## Test plan
- **Reset then RAM:** write `0xDEADBEEF` to `0x10` → the next-cycle read at `0x10` returns `0xDEADBEEF`; `bus_err`=0.
- **Faults:**
  - Read at `0x13` → `bus_err`=1, `bus_rdata`=0.
  - Write to `MEM_WORDS*4` → `bus_err`=1 and RAM unchanged.
  - Read of `CON_TX_ADDR` → `bus_err`=1.
- **Console order:** push `'H'`, `'i'`, `0x0A` with `con_ready`=0 → STAT reads 0. Then raise `con_ready` → `con_data` emits `0x48`, `0x69`, `0x0A` on consecutive cycles, then `con_valid`=0 and STAT=1.
- **Overflow:** 9 pushes with depth 8 and `con_ready`=0 → STAT=`0b110`. The next STAT read returns 2. The FIFO holds the first 8 bytes.
- **Full with push and pop:** with the FIFO full, push and pop in the same cycle → count stays 8, `ovf` stays 0, and the new byte is last out.
- **Reset mid-drain:** assert `bus_rst` with 5 entries and `con_ready`=1 → the next cycle has `con_valid`=0, STAT=1, and RAM is preserved.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared address-map constants, STAT bit layout and decode helpers for the data_bus slave.
package bus_pkg;

    localparam logic [31:0] CON_TX_ADDR   = 32'hFFFF_0000;
    localparam logic [31:0] CON_STAT_ADDR = 32'hFFFF_0004;

    localparam int STAT_EMPTY = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_OVF   = 2;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_TX,
        REG_STAT,
        REG_NONE
    } region_t;

    // Per-cycle qualified actions derived from one bus access.
    typedef struct packed {
        logic ram_rd;
        logic ram_wr;
        logic tx_push;
        logic stat_rd;
        logic err;
    } access_t;

    // ram_bytes is one bit wider than the address so a full 4 GiB RAM map still compares correctly.
    function automatic region_t decode_region(
        input logic [31:0] addr,
        input logic [32:0] ram_bytes,
        input logic [31:0] tx_addr,
        input logic [31:0] stat_addr
    );
        if ({1'b0, addr} < ram_bytes) begin
            return REG_RAM;
        end else if (addr == tx_addr) begin
            return REG_TX;
        end else if (addr == stat_addr) begin
            return REG_STAT;
        end
        return REG_NONE;
    endfunction

    function automatic logic [31:0] stat_word(
        input logic ovf,
        input logic full,
        input logic empty
    );
        logic [31:0] w;
        w = '0;
        w[STAT_EMPTY] = empty;
        w[STAT_FULL]  = full;
        w[STAT_OVF]   = ovf;
        return w;
    endfunction

endpackage

// File: rtl/con_fifo.sv
// Synchronous console FIFO: power-of-two depth, wrapping pointers and an extra-bit occupancy count.
module con_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic             dropped,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             pop_fire;
    logic             push_fire;

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign pop_fire  = pop & ~empty;
    // A pop frees the slot first, so a push into a full FIFO is still taken when draining.
    assign push_fire = push & (~full | pop_fire);
    assign dropped   = push & ~push_fire;
    assign head      = empty ? '0 : mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case ({push_fire, pop_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; head is masked while empty so stale entries never leak.
    always_ff @(posedge clk) begin
        if (!rst && push_fire) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/data_bus.sv
// Word-addressed bus slave for the single-cycle cpu: combinational RAM/STAT reads, RAM writes and a console TX FIFO.
module data_bus
    import bus_pkg::*;
#(
    parameter int unsigned MEM_WORDS     = 1024,
    parameter logic [31:0] CON_TX_ADDR   = bus_pkg::CON_TX_ADDR,
    parameter logic [31:0] CON_STAT_ADDR = bus_pkg::CON_STAT_ADDR,
    parameter int unsigned FIFO_DEPTH    = 8
) (
    input  logic        bus_clk,
    input  logic        bus_rst,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    input  logic        bus_rd,
    input  logic        bus_wr,
    output logic [31:0] bus_rdata,
    output logic        bus_err,
    output logic [7:0]  con_data,
    output logic        con_valid,
    input  logic        con_ready
);

    localparam int unsigned IDX_W     = $clog2(MEM_WORDS);
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [32:0] RAM_BYTES = 33'(MEM_WORDS) * 33'd4;

    logic [31:0]      ram [MEM_WORDS];
    logic [IDX_W-1:0] ram_idx;
    region_t          region;
    access_t          acc;
    logic             misaligned;
    logic             legal;

    logic             ovf;
    logic             fifo_push;
    logic             fifo_pop;
    logic [7:0]       fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_dropped;
    logic [CNT_W-1:0] fifo_count;

    assign ram_idx = bus_addr[IDX_W+1:2];

    // NOTE: every signal driven here gets a default first, so no branch can leave one unassigned and infer a latch.
    always_comb begin
        acc        = '0;
        region     = decode_region(bus_addr, RAM_BYTES, CON_TX_ADDR, CON_STAT_ADDR);
        misaligned = (bus_addr[1:0] != 2'b00);
        legal      = (bus_rd ^ bus_wr) && !misaligned &&
                     ((region == REG_RAM) ||
                      (region == REG_TX   && bus_wr) ||
                      (region == REG_STAT && bus_rd));
        acc.err    = (bus_rd | bus_wr) & ~legal;
        if (legal) begin
            case (region)
                REG_RAM: begin
                    acc.ram_rd = bus_rd;
                    acc.ram_wr = bus_wr;
                end
                REG_TX:   acc.tx_push = 1'b1;
                REG_STAT: acc.stat_rd = 1'b1;
                default:  acc = '0;
            endcase
        end
    end

    always_comb begin
        bus_rdata = '0;
        if (acc.ram_rd) begin
            bus_rdata = ram[ram_idx];
        end else if (acc.stat_rd) begin
            bus_rdata = stat_word(ovf, fifo_full, fifo_empty);
        end
    end

    assign bus_err = acc.err;

    always_ff @(posedge bus_clk) begin
        if (!bus_rst && acc.ram_wr) begin
            ram[ram_idx] <= bus_wdata;
        end
    end

    // A dropped push and a STAT read in the same cycle leave ovf set.
    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            ovf <= 1'b0;
        end else if (fifo_dropped) begin
            ovf <= 1'b1;
        end else if (acc.stat_rd) begin
            ovf <= 1'b0;
        end
    end

    assign fifo_push = acc.tx_push & ~bus_rst;
    assign fifo_pop  = con_valid & con_ready;

    con_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_con_fifo (
        .clk       (bus_clk),
        .rst       (bus_rst),
        .push      (fifo_push),
        .push_data (bus_wdata[7:0]),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .dropped   (fifo_dropped),
        .count     (fifo_count)
    );

    assign con_valid = ~fifo_empty;
    assign con_data  = fifo_head;

    count_bound_a: assert property (
        @(posedge bus_clk) disable iff (bus_rst) fifo_count <= CNT_W'(FIFO_DEPTH)
    );

    sink_stable_a: assert property (
        @(posedge bus_clk) disable iff (bus_rst)
        (con_valid && !con_ready) |=> $stable(con_data)
    );

endmodule

// File: tb/tb_data_bus.sv
// Self-checking bench for data_bus: directed scenarios with literal expectations plus a randomized run against a queue-based model.
module tb_data_bus;

    localparam int unsigned MEM_WORDS  = 1024;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam logic [31:0] TX_ADDR    = 32'hFFFF_0000;
    localparam logic [31:0] STAT_ADDR  = 32'hFFFF_0004;
    localparam logic [31:0] RAM_END    = 32'(MEM_WORDS * 4);

    logic        bus_clk   = 1'b0;
    logic        bus_rst   = 1'b1;
    logic [31:0] bus_addr  = '0;
    logic [31:0] bus_wdata = '0;
    logic        bus_rd    = 1'b0;
    logic        bus_wr    = 1'b0;
    logic [31:0] bus_rdata;
    logic        bus_err;
    logic [7:0]  con_data;
    logic        con_valid;
    logic        con_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: the FIFO as a byte queue, the sticky overflow bit and the RAM words written so far.
    byte unsigned q[$];
    bit           ovf_m = 1'b0;
    logic [31:0]  ram_m [int unsigned];

    always #5 bus_clk = ~bus_clk;

    data_bus #(
        .MEM_WORDS     (MEM_WORDS),
        .CON_TX_ADDR   (TX_ADDR),
        .CON_STAT_ADDR (STAT_ADDR),
        .FIFO_DEPTH    (FIFO_DEPTH)
    ) dut (
        .bus_clk   (bus_clk),
        .bus_rst   (bus_rst),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rd    (bus_rd),
        .bus_wr    (bus_wr),
        .bus_rdata (bus_rdata),
        .bus_err   (bus_err),
        .con_data  (con_data),
        .con_valid (con_valid),
        .con_ready (con_ready)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare the current cycle against the model, then advance the model across the coming edge.
    task automatic model_cycle();
        logic [31:0] a;
        bit          rd, wr, aligned, in_ram, legal, known, drop;
        logic [31:0] exp_rdata;
        int unsigned widx;
        a       = bus_addr;
        rd      = bus_rd;
        wr      = bus_wr;
        widx    = int'(a >> 2);
        aligned = (a % 4 == 0);
        in_ram  = ({32'b0, a} < 64'(MEM_WORDS) * 64'd4);
        legal   = (rd != wr) && aligned && (in_ram || (a == TX_ADDR && wr) || (a == STAT_ADDR && rd));

        exp_rdata = '0;
        known     = 1'b1;
        if (legal && rd) begin
            if (in_ram) begin
                if (ram_m.exists(widx)) exp_rdata = ram_m[widx];
                else known = 1'b0;
            end else begin
                exp_rdata = 32'(ovf_m) * 4 + ((q.size() == FIFO_DEPTH) ? 2 : 0) + ((q.size() == 0) ? 1 : 0);
            end
        end

        check("model_err", {31'b0, bus_err}, {31'b0, (rd || wr) && !legal});
        if (known) check("model_rdata", bus_rdata, exp_rdata);
        check("model_valid", {31'b0, con_valid}, {31'b0, q.size() != 0});
        check("model_data", {24'b0, con_data}, (q.size() != 0) ? {24'b0, q[0]} : 32'h0);

        if (bus_rst) begin
            q.delete();
            ovf_m = 1'b0;
        end else begin
            drop = 1'b0;
            if (q.size() > 0 && con_ready) void'(q.pop_front());
            if (legal && wr && a == TX_ADDR) begin
                if (q.size() < FIFO_DEPTH) q.push_back(bus_wdata[7:0]);
                else drop = 1'b1;
            end
            if (legal && rd && a == STAT_ADDR) ovf_m = 1'b0;
            if (drop) ovf_m = 1'b1;
            if (legal && wr && in_ram) ram_m[widx] = bus_wdata;
        end
    endtask

    initial begin
        @(posedge bus_clk);
        forever begin
            @(negedge bus_clk);
            model_cycle();
        end
    end

    task automatic cyc();
        @(posedge bus_clk);
        #1;
    endtask

    task automatic drive(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        bus_rd    = rd;
        bus_wr    = wr;
        bus_addr  = a;
        bus_wdata = d;
    endtask

    task automatic push_byte(input logic [7:0] b);
        cyc();
        drive(1'b0, 1'b1, TX_ADDR, {24'h123456, b});
    endtask

    task automatic random_cycle();
        int unsigned sel, mode;
        logic [31:0] a;
        sel  = $urandom_range(0, 11);
        mode = $urandom_range(0, 9);
        case (sel)
            0, 1, 2, 3: a = 32'($urandom_range(0, 15)) * 4;
            4:          a = RAM_END - 4;
            5:          a = RAM_END + 32'($urandom_range(0, 3)) * 4;
            6:          a = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
            7, 8, 9:    a = TX_ADDR;
            default:    a = STAT_ADDR;
        endcase
        cyc();
        bus_rst   = ($urandom_range(0, 149) == 0);
        con_ready = ($urandom_range(0, 2) == 0);
        case (mode)
            0, 1:       drive(1'b0, 1'b0, a, $urandom);
            2, 3, 4, 5: drive(1'b0, 1'b1, a, $urandom);
            6, 7, 8:    drive(1'b1, 1'b0, a, $urandom);
            default:    drive(1'b1, 1'b1, a, $urandom);
        endcase
    endtask

    initial begin
        repeat (3) cyc();
        bus_rst = 1'b0;
        #2;
        check("rst_valid", {31'b0, con_valid}, 32'h0);
        check("rst_data", {24'b0, con_data}, 32'h0);
        check("rst_rdata", bus_rdata, 32'h0);
        check("rst_err", {31'b0, bus_err}, 32'h0);

        cyc(); drive(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        cyc(); drive(1'b1, 1'b0, 32'h10, 32'h0);
        #2;
        check("ram_rd_10", bus_rdata, 32'hDEAD_BEEF);
        check("ram_rd_10_err", {31'b0, bus_err}, 32'h0);
        cyc(); drive(1'b0, 1'b1, 32'h0, 32'h1111_1111);
        cyc(); drive(1'b1, 1'b0, 32'h13, 32'h0);
        #2;
        check("misalign_err", {31'b0, bus_err}, 32'h1);
        check("misalign_rdata", bus_rdata, 32'h0);
        cyc(); drive(1'b0, 1'b1, RAM_END, 32'hBAD0_BAD0);
        #2;
        check("oob_wr_err", {31'b0, bus_err}, 32'h1);
        cyc(); drive(1'b1, 1'b0, 32'h0, 32'h0);
        #2;
        check("oob_ram_unchanged", bus_rdata, 32'h1111_1111);
        cyc(); drive(1'b1, 1'b0, TX_ADDR, 32'h0);
        #2;
        check("tx_rd_err", {31'b0, bus_err}, 32'h1);
        check("tx_rd_rdata", bus_rdata, 32'h0);
        cyc(); drive(1'b1, 1'b1, 32'h10, 32'h5555_5555);
        #2;
        check("both_err", {31'b0, bus_err}, 32'h1);
        check("both_rdata", bus_rdata, 32'h0);
        cyc(); drive(1'b1, 1'b0, 32'h10, 32'h0);
        #2;
        check("both_no_write", bus_rdata, 32'hDEAD_BEEF);

        push_byte(8'h48);
        push_byte(8'h69);
        push_byte(8'h0A);
        cyc(); drive(1'b1, 1'b0, STAT_ADDR, 32'h0);
        #2;
        check("con_stat_3", bus_rdata, 32'h0);
        cyc(); drive(1'b0, 1'b0, 32'h0, 32'h0); con_ready = 1'b1;
        #2; check("con_ch0", {24'b0, con_data}, 32'h48);
        cyc(); #2; check("con_ch1", {24'b0, con_data}, 32'h69);
        cyc(); #2; check("con_ch2", {24'b0, con_data}, 32'h0A);
        cyc(); drive(1'b1, 1'b0, STAT_ADDR, 32'h0);
        #2;
        check("con_drained_valid", {31'b0, con_valid}, 32'h0);
        check("con_drained_stat", bus_rdata, 32'h1);

        cyc(); drive(1'b0, 1'b0, 32'h0, 32'h0); con_ready = 1'b0;
        for (int i = 0; i < 9; i++) push_byte(8'hA0 + 8'(i));
        cyc(); drive(1'b1, 1'b0, STAT_ADDR, 32'h0);
        #2; check("ovf_stat", bus_rdata, 32'h6);
        cyc(); drive(1'b1, 1'b0, STAT_ADDR, 32'h0);
        #2; check("ovf_cleared_stat", bus_rdata, 32'h2);
        cyc(); drive(1'b0, 1'b0, 32'h0, 32'h0); con_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #2; check("ovf_drain", {24'b0, con_data}, 32'hA0 + 32'(i));
            cyc();
        end
        #2; check("ovf_drain_empty", {31'b0, con_valid}, 32'h0);

        con_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_byte(8'hB0 + 8'(i));
        cyc(); drive(1'b0, 1'b1, TX_ADDR, 32'hC0); con_ready = 1'b1;
        #2; check("full_head", {24'b0, con_data}, 32'hB0);
        cyc(); drive(1'b1, 1'b0, STAT_ADDR, 32'h0); con_ready = 1'b0;
        #2; check("full_pushpop_stat", bus_rdata, 32'h2);
        cyc(); drive(1'b0, 1'b0, 32'h0, 32'h0); con_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            #2; check("full_drain", {24'b0, con_data}, 32'hB0 + 32'(i));
            cyc();
        end
        #2; check("full_last_out", {24'b0, con_data}, 32'hC0);
        cyc(); con_ready = 1'b0;

        for (int i = 0; i < 5; i++) push_byte(8'hD0 + 8'(i));
        cyc(); drive(1'b0, 1'b1, 32'h10, 32'h0BAD_F00D); con_ready = 1'b1; bus_rst = 1'b1;
        cyc(); drive(1'b1, 1'b0, STAT_ADDR, 32'h0); bus_rst = 1'b0;
        #2;
        check("rst_mid_valid", {31'b0, con_valid}, 32'h0);
        check("rst_mid_stat", bus_rdata, 32'h1);
        cyc(); drive(1'b1, 1'b0, 32'h10, 32'h0);
        #2; check("rst_mid_ram", bus_rdata, 32'hDEAD_BEEF);

        for (int n = 0; n < 3000; n++) random_cycle();
        cyc(); drive(1'b0, 1'b0, 32'h0, 32'h0); bus_rst = 1'b0; con_ready = 1'b1;
        repeat (FIFO_DEPTH + 2) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
